// File: rtl/column_mac_engine.sv
// Row-sequential dot-product engine fed by a combinational weight ROM.
// One signed MAC per cycle; saturated Q-format results over valid/ready.
module column_mac_engine #(
  parameter int N    = 8,
  parameter int S    = 8,
  parameter int n    = 32,
  parameter int FRAC = 16,
  parameter int AW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*n-1:0] x_in,
  output logic [AW-1:0]  addr,
  input  logic [N*n-1:0] W,
  output logic [n-1:0]   y_out,
  output logic [AW-1:0]  y_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int AccW = 2*n + IW;
  localparam logic [IW-1:0] LaneLast = IW'(N-1);
  localparam logic [AW-1:0] RowLast  = AW'(S-1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nx;

  logic [IW-1:0]          lane;
  logic [N*n-1:0]         xr;
  logic signed [AccW-1:0] acc, acc_nx, acc_sh;
  logic signed [n-1:0]    w_l, x_l;
  logic signed [2*n-1:0]  w_e, x_e, prod;
  logic [AccW-n:0]        hi;
  logic                   fits;
  logic [n-1:0]           sat;
  logic                   last_lane, last_row;

  assign w_l = W[int'(lane)*n +: n];
  assign x_l = xr[int'(lane)*n +: n];
  assign w_e = {{n{w_l[n-1]}}, w_l};
  assign x_e = {{n{x_l[n-1]}}, x_l};
  assign prod = w_e * x_e;
  assign acc_nx = acc + {{IW{prod[2*n-1]}}, prod};
  assign acc_sh = acc_nx >>> FRAC;

  // result fits in n bits iff all bits above the sign bit match it
  assign hi   = acc_sh[AccW-1:n-1];
  assign fits = (&hi) | ~(|hi);
  assign sat  = fits ? acc_sh[n-1:0] :
                acc_sh[AccW-1] ? {1'b1, {(n-1){1'b0}}} :
                                 {1'b0, {(n-1){1'b1}}};

  assign last_lane = (lane == LaneLast);
  assign last_row  = (addr == RowLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = MAC;
      MAC:  if (last_lane) state_nx = OUT;
      OUT:  if (out_ready) state_nx = last_row ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      y_out     <= '0;
      y_row     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc       <= '0;
      lane      <= '0;
      xr        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          xr   <= x_in;
          addr <= '0;
          lane <= '0;
          acc  <= '0;
          busy <= 1'b1;
        end
        MAC: begin
          acc  <= acc_nx;
          lane <= lane + IW'(1);
          if (last_lane) begin
            y_out     <= sat;
            y_row     <= addr;
            out_valid <= 1'b1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          lane      <= '0;
          acc       <= '0;
          if (last_row) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_column_mac_engine.sv
// Scoreboard bench for column_mac_engine: ROM model, arithmetic reference,
// decoupled monitor checking values, row order, latency and done timing.
module tb_column_mac_engine;

  localparam int N  = 8;
  localparam int S  = 8;
  localparam int NB = 32;
  localparam int AW = 3;
  localparam int PASS_LEN = S*(N+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N*NB-1:0]   x_in = '0;
  logic [AW-1:0]     addr;
  logic [N*NB-1:0]   w;
  logic [NB-1:0]     y_out;
  logic [AW-1:0]     y_row;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;

  column_mac_engine #(.N(N), .S(S), .n(NB), .FRAC(16), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .addr(addr),
    .W(w), .y_out(y_out), .y_row(y_row), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rom [S][N];
  logic [31:0] xv [N];

  always_comb begin
    w = '0;
    for (int i = 0; i < N; i++) w[i*NB +: NB] = rom[addr][i];
  end

  typedef struct packed {
    logic [AW-1:0] row;
    logic [31:0]   y;
  } exp_t;

  exp_t q[$];
  logic [31:0] got [S];

  int n_checks = 0;
  int n_fail = 0;
  int ref_edge = 0;
  int done_edge = -1000;
  int sedge = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // plain fixed-point dot product with floor shift and clamp
  function automatic logic [31:0] ref_y(input int s);
    logic signed [66:0] sum;
    logic signed [66:0] a, b;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      a = 67'($signed(rom[s][i]));
      b = 67'($signed(xv[i]));
      sum = sum + a * b;
    end
    sum = sum >>> 16;
    if (sum > 67'sd2147483647) return 32'h7FFF_FFFF;
    if (sum < -67'sd2147483648) return 32'h8000_0000;
    return sum[31:0];
  endfunction

  // monitor: samples on the falling edge, away from the active edge
  logic          pv = 1'b0;
  logic [31:0]   hy;
  logic [AW-1:0] hr;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (out_valid && !pv)
        check("valid_latency", cyc, ref_edge + N);
      if (out_valid && pv) begin
        check("stall_y_hold", y_out, hy);
        check("stall_row_hold", 32'(y_row), 32'(hr));
        check("stall_addr_hold", 32'(addr), 32'(hr));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_row", 32'(y_row), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("row_order", 32'(y_row), 32'(e.row));
          check("y_value", y_out, e.y);
          got[y_row] = y_out;
          ref_edge = cyc + 1;
          if (e.row == AW'(S-1)) done_edge = cyc + 1;
        end
      end
      if (done) check("done_time", cyc, done_edge);
      pv = out_valid;
      hy = y_out;
      hr = y_row;
    end
  end

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 32'h3_FFFF)) - 32'h1_FFFF;
      2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
    endcase
  endfunction

  task automatic load_x_and_expect();
    for (int i = 0; i < N; i++) x_in[i*NB +: NB] = xv[i];
    for (int s = 0; s < S; s++) q.push_back('{row: AW'(s), y: ref_y(s)});
  endtask

  task automatic issue_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sedge = cyc;
    ref_edge = cyc;
  endtask

  // mode 0: ready high; 1: random ready; 2: stall on row 4 plus disturbances
  task automatic run_pass(input int mode);
    int k;
    int bp_cnt;
    bit bp_done;
    bit got_done;
    load_x_and_expect();
    out_ready = 1'b1;
    issue_start();
    k = 0;
    bp_cnt = 0;
    bp_done = 1'b0;
    got_done = 1'b0;
    while (!got_done && k < 3000) begin
      if (mode == 1) out_ready = ($urandom_range(0, 1) != 0);
      if (mode == 2) begin
        start = (k == 5);
        if (k == 5)
          for (int i = 0; i < N; i++) x_in[i*NB +: NB] = $urandom;
        if (out_valid && y_row == 3'd4 && !bp_done) begin
          out_ready = 1'b0;
          bp_cnt = 5;
          bp_done = 1'b1;
        end else if (bp_cnt > 0) begin
          bp_cnt--;
          if (bp_cnt == 0) out_ready = 1'b1;
        end
      end
      @(posedge clk); #1;
      k++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    if (mode == 0) check("pass_length", cyc - sedge, PASS_LEN);
    if (mode == 2) check("pass_length_stall", cyc - sedge, PASS_LEN + 5);
    check("queue_drained", q.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic base_rom();
    for (int s = 0; s < S; s++)
      for (int i = 0; i < N; i++) rom[s][i] = 32'h0001_0000;
    for (int s = 0; s < S; s++) rom[s][N-1] = 32'h0001_0000 + 32'(s * 32'h100);
    rom[0][N-1] = 32'h0001_1000;
    rom[2][N-1] = 32'h0001_0010;
    rom[3][N-1] = 32'h0001_0001;
  endtask

  task automatic fill_x(input logic [31:0] v);
    for (int i = 0; i < N; i++) xv[i] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_y_out"}, y_out, 0);
    check({tag, "_y_row"}, 32'(y_row), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    base_rom();
    fill_x(32'h0);
    #12;
    check_reset_outputs("reset");
    #11 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fill_x(32'h0001_0000);
    run_pass(0);
    check("unit_row0", got[0], 32'h0008_1000);
    check("unit_row3", got[3], 32'h0008_0001);

    fill_x(32'hFFFF_0000);
    run_pass(0);
    check("neg_row0", got[0], 32'hFFF7_F000);
    check("neg_row2", got[2], 32'hFFF7_FFF0);

    fill_x(32'h7FFF_0000);
    run_pass(0);
    check("sat_pos_row0", got[0], 32'h7FFF_FFFF);
    check("sat_pos_row7", got[7], 32'h7FFF_FFFF);

    fill_x(32'h8000_0000);
    run_pass(0);
    check("sat_neg_row0", got[0], 32'h8000_0000);
    check("sat_neg_row7", got[7], 32'h8000_0000);

    for (int i = 0; i < N; i++) xv[i] = rnd32();
    run_pass(2);

    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1;
      for (int s = 0; s < S; s++)
        for (int i = 0; i < N; i++) rom[s][i] = rnd32();
      for (int i = 0; i < N; i++) xv[i] = rnd32();
      run_pass(1);
    end

    base_rom();
    for (int i = 0; i < N; i++) xv[i] = rnd32();
    load_x_and_expect();
    issue_start();
    repeat (2*(N+1) + 3) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", 32'(busy), 1);
    check("pre_reset_addr", 32'(addr), 2);
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy || out_valid) check("idle_after_reset", 32'(busy), 0);
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(out_valid), 0);

    for (int i = 0; i < N; i++) xv[i] = rnd32();
    run_pass(0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
